// File: rtl/lvds_pkg.sv
// Shared types and constants for the parametrised LVDS serial transmitter.
// Optional parity is selected with the LVDS_TX_PARITY_EN macro.
package lvds_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

`ifdef LVDS_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Total clocks from the accept edge to the end of the last stop bit.
    function automatic int frame_len(input int data_w, input int clks_per_bit, input int stop_bits);
        return (1 + data_w + PARITY_BITS + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/lvds_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and strobes on the last clock of each bit.
// o_pre_tick marks the clock before o_tick (always low when CLKS_PER_BIT is 1).
module lvds_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick,
    output logic o_pre_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == CNT_LAST);

    generate
        if (CLKS_PER_BIT > 1) begin : g_pre
            assign o_pre_tick = (r_cnt == CNT_W'(CLKS_PER_BIT - 2));
        end else begin : g_no_pre
            assign o_pre_tick = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/lvds_tx_param.sv
// Parametrised LVDS frame serialiser: start bit, DATA_W data bits, optional even parity,
// STOP_BITS stop bits. Parity is enabled by defining LVDS_TX_PARITY_EN.
module lvds_tx_param
    import lvds_pkg::*;
#(
    parameter int DATA_W       = 24,
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy,
    output logic              frame_done
);

    localparam int DBIT_W = $clog2(DATA_W + 1);
    localparam int SBIT_W = $clog2(STOP_BITS + 1);
    localparam int BIT_W  = (DBIT_W > SBIT_W) ? DBIT_W : SBIT_W;
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

    // The final clock of the last stop bit is spent in IDLE so a new start bit can
    // follow with no gap; STOP therefore ends one clock early.
    localparam bit STOP_SKIP = (CLKS_PER_BIT == 1) && (STOP_BITS == 1);
    localparam int STOP_END_IDX = (CLKS_PER_BIT == 1) ? ((STOP_BITS > 1) ? STOP_BITS - 2 : 0)
                                                      : STOP_BITS - 1;
    localparam logic [BIT_W-1:0] STOP_END = BIT_W'(STOP_END_IDX);

    state_t            r_state;
    logic [DATA_W-1:0] r_sr;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_tx;
    logic              r_done;
`ifdef LVDS_TX_PARITY_EN
    logic              r_parity;
`endif

    logic w_accept;
    logic w_tick;
    logic w_pre_tick;
    logic w_stop_strobe;
    logic w_stop_end;
    logic w_payload_end;

    assign tx_ready   = (r_state == ST_IDLE) && !rst;
    assign tx_busy    = (r_state != ST_IDLE);
    assign tx         = r_tx;
    assign frame_done = r_done;
    assign w_accept   = tx_valid && tx_ready;

    lvds_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_accept),
        .o_tick    (w_tick),
        .o_pre_tick(w_pre_tick)
    );

    assign w_stop_strobe = (CLKS_PER_BIT == 1) ? w_tick : w_pre_tick;
    assign w_stop_end    = (r_state == ST_STOP) && w_stop_strobe && (r_bit_cnt == STOP_END);

`ifdef LVDS_TX_PARITY_EN
    assign w_payload_end = (r_state == ST_PARITY) && w_tick;
`else
    assign w_payload_end = (r_state == ST_DATA) && w_tick && (r_bit_cnt == DATA_LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_tx      <= LINE_IDLE;
            r_done    <= 1'b0;
`ifdef LVDS_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_payload_end) begin
                r_bit_cnt <= '0;
                r_tx      <= STOP_LVL;
                if (STOP_SKIP) begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= ST_STOP;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_tx <= LINE_IDLE;
                        if (w_accept) begin
                            r_state   <= ST_START;
                            r_sr      <= data_in;
                            r_bit_cnt <= '0;
                            r_tx      <= START_LVL;
`ifdef LVDS_TX_PARITY_EN
                            r_parity  <= ^data_in;
`endif
                        end
                    end
                    ST_START: begin
                        if (w_tick) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                            if (LSB_FIRST != 0) begin
                                r_tx <= r_sr[0];
                                r_sr <= r_sr >> 1;
                            end else begin
                                r_tx <= r_sr[DATA_W-1];
                                r_sr <= r_sr << 1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_tick) begin
`ifdef LVDS_TX_PARITY_EN
                            if (r_bit_cnt == DATA_LAST) begin
                                r_state <= ST_PARITY;
                                r_tx    <= r_parity;
                            end else
`endif
                            begin
                                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                                if (LSB_FIRST != 0) begin
                                    r_tx <= r_sr[0];
                                    r_sr <= r_sr >> 1;
                                end else begin
                                    r_tx <= r_sr[DATA_W-1];
                                    r_sr <= r_sr << 1;
                                end
                            end
                        end
                    end
                    ST_STOP: begin
                        r_tx <= STOP_LVL;
                        if (w_stop_end) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else if (w_tick) begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tx    <= LINE_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
